cr_logic_unit: RTL and testbench

- Parametrised successor to the combinational CR bit-logic block.
- Owns the condition register state and executes CR logical ops (and/or/nand/nor/xor/eqv/andc/orc), mcrf and mtcrf behind a valid/ready handshake.
- Has a registered one-cycle result stage and a side write port for compare results from the fixed-point unit.
- Sits between decode/issue and the branch unit; cr_out feeds branch condition evaluation.

---
 rtl/cr_logic_unit_if.sv | 50 +++++
 rtl/cr_logic_unit.sv | 156 +++++++++++++++
 tb/tb_cr_logic_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cr_logic_unit_if.sv
// cr_logic_unit_if
// Groups the condition-register unit's op request, compare side-write,
// CR state and result handshake into one bundle.
//   master : issue/decode side (drives requests, compare writes, out_ready)
//   slave  : cr_logic_unit (drives in_ready, cr_out and the result stage)
// Signals:
//   in_valid/in_ready          op request handshake
//   in_op, in_sel_a/b/t        opcode and bit selectors
//   in_mask, in_data           mtcrf field mask and data
//   cmp_we/cmp_field/cmp_val   compare-result field write
//   cr_out                     registered CR state
//   out_valid/out_ready        result handshake
//   out_bit, out_sel_t, out_err  result payload
interface cr_logic_unit_if #(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_BITS = 4
);
  localparam int SEL_W  = $clog2(NUM_FIELDS * FIELD_BITS);
  localparam int FIDX_W = $clog2(NUM_FIELDS);

  logic                             in_valid;
  logic                             in_ready;
  logic [3:0]                       in_op;
  logic [SEL_W-1:0]                 in_sel_a;
  logic [SEL_W-1:0]                 in_sel_b;
  logic [SEL_W-1:0]                 in_sel_t;
  logic [NUM_FIELDS-1:0]            in_mask;
  logic [NUM_FIELDS*FIELD_BITS-1:0] in_data;
  logic                             cmp_we;
  logic [FIDX_W-1:0]                cmp_field;
  logic [FIELD_BITS-1:0]            cmp_val;
  logic [NUM_FIELDS*FIELD_BITS-1:0] cr_out;
  logic                             out_valid;
  logic                             out_ready;
  logic                             out_bit;
  logic [SEL_W-1:0]                 out_sel_t;
  logic                             out_err;

  modport master (
    output in_valid, in_op, in_sel_a, in_sel_b, in_sel_t, in_mask, in_data,
    output cmp_we, cmp_field, cmp_val, out_ready,
    input  in_ready, cr_out, out_valid, out_bit, out_sel_t, out_err
  );

  modport slave (
    input  in_valid, in_op, in_sel_a, in_sel_b, in_sel_t, in_mask, in_data,
    input  cmp_we, cmp_field, cmp_val, out_ready,
    output in_ready, cr_out, out_valid, out_bit, out_sel_t, out_err
  );
endinterface

// File: rtl/cr_logic_unit.sv
// cr_logic_unit
// Owns the condition register and executes CR logical ops, mcrf and mtcrf
// behind a valid/ready handshake with a one-entry registered result stage.
// A side port lets the fixed-point unit write compare results into a field.
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    cr_logic_unit_if.slave (request, compare write, CR, result)
// Selector k addresses field k/FIELD_BITS, bit FIELD_BITS-1-(k mod FIELD_BITS)
// of that field; field i sits at cr_out[i*FIELD_BITS +: FIELD_BITS].
module cr_logic_unit #(
  parameter int NUM_FIELDS = 8,
  parameter int FIELD_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  cr_logic_unit_if.slave  bus
);
  localparam int CR_W  = NUM_FIELDS * FIELD_BITS;
  localparam int SEL_W = $clog2(CR_W);

  logic [CR_W-1:0]       r_cr;
  logic                  r_out_valid;
  logic                  r_out_bit;
  logic [SEL_W-1:0]      r_out_sel_t;
  logic                  r_out_err;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_is_logic;
  logic                  w_is_mcrf;
  logic                  w_is_mtcrf;
  logic                  w_err;
  logic                  w_bit_a;
  logic                  w_bit_b;
  logic                  w_res;
  logic [FIELD_BITS-1:0] w_src_field;
  logic [CR_W-1:0]       w_cr_next;
  int                    w_sa;
  int                    w_sb;
  int                    w_st;
  int                    w_pos_a;
  int                    w_pos_b;
  int                    w_pos_t;

  // Flat CR bit position of a selector (big-endian within its field).
  function automatic int bit_pos(input int sel);
    return (sel / FIELD_BITS) * FIELD_BITS + (FIELD_BITS - 1 - (sel % FIELD_BITS));
  endfunction

  assign w_ready  = !r_out_valid || bus.out_ready;
  assign w_accept = bus.in_valid && w_ready && reset;

  // Decode and range checks. Only selectors the op actually uses can flag
  // an error; mtcrf uses none.
  always_comb begin
    w_sa       = int'(bus.in_sel_a);
    w_sb       = int'(bus.in_sel_b);
    w_st       = int'(bus.in_sel_t);
    w_pos_a    = bit_pos(w_sa);
    w_pos_b    = bit_pos(w_sb);
    w_pos_t    = bit_pos(w_st);
    w_is_logic = !bus.in_op[3];
    w_is_mcrf  = (bus.in_op == 4'd8);
    w_is_mtcrf = (bus.in_op == 4'd9);
    w_err      = !(w_is_logic || w_is_mcrf || w_is_mtcrf);
    if (w_is_logic && (w_sa >= CR_W || w_sb >= CR_W || w_st >= CR_W)) begin
      w_err = 1'b1;
    end
    if (w_is_mcrf && (w_sa >= CR_W || w_st >= CR_W)) begin
      w_err = 1'b1;
    end
  end

  // Operand fetch always from the pre-edge CR register.
  always_comb begin
    w_bit_a     = 1'b0;
    w_bit_b     = 1'b0;
    w_src_field = '0;
    for (int j = 0; j < CR_W; j++) begin
      if (j == w_pos_a) w_bit_a = r_cr[j];
      if (j == w_pos_b) w_bit_b = r_cr[j];
    end
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (i == w_sa / FIELD_BITS) w_src_field = r_cr[i*FIELD_BITS +: FIELD_BITS];
    end
  end

  always_comb begin
    w_res = 1'b0;
    unique case (bus.in_op[2:0])
      3'd0: w_res = w_bit_a & w_bit_b;
      3'd1: w_res = w_bit_a | w_bit_b;
      3'd2: w_res = ~(w_bit_a & w_bit_b);
      3'd3: w_res = ~(w_bit_a | w_bit_b);
      3'd4: w_res = w_bit_a ^ w_bit_b;
      3'd5: w_res = ~(w_bit_a ^ w_bit_b);
      3'd6: w_res = w_bit_a & ~w_bit_b;
      3'd7: w_res = w_bit_a | ~w_bit_b;
      default: w_res = 1'b0;
    endcase
  end

  // Next CR: compare write first, then the accepted op on top of it so the
  // op wins where they overlap. An out-of-range cmp_field matches no field.
  always_comb begin
    w_cr_next = r_cr;
    if (bus.cmp_we) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (int'(bus.cmp_field) == i) w_cr_next[i*FIELD_BITS +: FIELD_BITS] = bus.cmp_val;
      end
    end
    if (w_accept && !w_err) begin
      if (w_is_logic) begin
        for (int j = 0; j < CR_W; j++) begin
          if (j == w_pos_t) w_cr_next[j] = w_res;
        end
      end else if (w_is_mcrf) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (i == w_st / FIELD_BITS) w_cr_next[i*FIELD_BITS +: FIELD_BITS] = w_src_field;
        end
      end else if (w_is_mtcrf) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (bus.in_mask[i]) w_cr_next[i*FIELD_BITS +: FIELD_BITS] = bus.in_data[i*FIELD_BITS +: FIELD_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cr        <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_sel_t <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_cr <= w_cr_next;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_bit   <= w_is_logic && !w_err && w_res;
        r_out_sel_t <= bus.in_sel_t;
        r_out_err   <= w_err;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.cr_out    = r_cr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bit   = r_out_bit;
  assign bus.out_sel_t = r_out_sel_t;
  assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_cr_logic_unit.sv
// Directed bench for cr_logic_unit (8 fields x 4 bits).
// Selector k maps to cr_out bit (k/4)*4 + 3 - k%4.
module tb_cr_logic_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cr_logic_unit_if #(.NUM_FIELDS(8), .FIELD_BITS(4)) bus ();

  cr_logic_unit #(.NUM_FIELDS(8), .FIELD_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_sel_a  = '0;
    bus.in_sel_b  = '0;
    bus.in_sel_t  = '0;
    bus.in_mask   = '0;
    bus.in_data   = '0;
    bus.cmp_we    = 1'b0;
    bus.cmp_field = '0;
    bus.cmp_val   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] t);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_sel_a = a;
    bus.in_sel_b = b;
    bus.in_sel_t = t;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    bus.cmp_we = 1'b1; bus.cmp_field = 3'd1; bus.cmp_val = 4'hF;
    issue(4'd9, 5'd0, 5'd0, 5'd0);
    bus.in_mask = 8'hFF; bus.in_data = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++; if (bus.cr_out !== 32'h0) begin errors++; $display("FAIL reset_cr got %h exp %h", bus.cr_out, 32'h0); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_bit got %b exp 0", bus.out_bit); end
    checks++; if (bus.out_sel_t !== 5'd0) begin errors++; $display("FAIL reset_out_sel_t got %0d exp 0", bus.out_sel_t); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b exp 0", bus.out_err); end
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_cmp_and();
    bus.cmp_we = 1'b1; bus.cmp_field = 3'd0; bus.cmp_val = 4'b1000;
    tick();
    bus.cmp_we = 1'b0;
    checks++; if (bus.cr_out !== 32'h0000_0008) begin errors++; $display("FAIL cmp_write got %h exp %h", bus.cr_out, 32'h0000_0008); end
    issue(4'd0, 5'd0, 5'd0, 5'd31);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL and_out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_bit !== 1'b1) begin errors++; $display("FAIL and_out_bit got %b exp 1", bus.out_bit); end
    checks++; if (bus.out_sel_t !== 5'd31) begin errors++; $display("FAIL and_out_sel_t got %0d exp 31", bus.out_sel_t); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL and_out_err got %b exp 0", bus.out_err); end
    checks++; if (bus.cr_out !== 32'h1000_0008) begin errors++; $display("FAIL and_cr got %h exp %h", bus.cr_out, 32'h1000_0008); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL and_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic exp_bit [4];
    exp_bit[0] = 1'b1; exp_bit[1] = 1'b0; exp_bit[2] = 1'b1; exp_bit[3] = 1'b0;
    issue(4'd3, 5'd1, 5'd2, 5'd1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, bus.in_ready); end
      tick();
      checks++; if (bus.cr_out[2] !== exp_bit[i]) begin errors++; $display("FAIL b2b_cr_bit[%0d] got %b exp %b", i, bus.cr_out[2], exp_bit[i]); end
      checks++; if (bus.out_bit !== exp_bit[i]) begin errors++; $display("FAIL b2b_out_bit[%0d] got %b exp %b", i, bus.out_bit, exp_bit[i]); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d] got %b exp 1", i, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.cr_out !== 32'h1000_0008) begin errors++; $display("FAIL b2b_cr got %h exp %h", bus.cr_out, 32'h1000_0008); end
  endtask

  task automatic test_mtcrf_mcrf();
    issue(4'd9, 5'd0, 5'd0, 5'd0);
    bus.in_mask = 8'b1000_0001; bus.in_data = 32'hA000_0005;
    tick();
    checks++; if (bus.cr_out !== 32'hA000_0005) begin errors++; $display("FAIL mtcrf_cr got %h exp %h", bus.cr_out, 32'hA000_0005); end
    checks++; if (bus.out_bit !== 1'b0 || bus.out_err !== 1'b0) begin errors++; $display("FAIL mtcrf_out got bit %b err %b exp 0 0", bus.out_bit, bus.out_err); end
    bus.in_mask = 8'h00; bus.in_data = 32'hFFFF_FFFF;
    tick();
    checks++; if (bus.cr_out !== 32'hA000_0005) begin errors++; $display("FAIL mtcrf_mask0 got %h exp %h", bus.cr_out, 32'hA000_0005); end
    issue(4'd8, 5'd0, 5'd0, 5'd28);
    tick();
    checks++; if (bus.cr_out !== 32'h5000_0005) begin errors++; $display("FAIL mcrf_cr got %h exp %h", bus.cr_out, 32'h5000_0005); end
    checks++; if (bus.out_sel_t !== 5'd28) begin errors++; $display("FAIL mcrf_sel_t got %0d exp 28", bus.out_sel_t); end
    issue(4'd8, 5'd4, 5'd0, 5'd5);
    tick();
    checks++; if (bus.cr_out !== 32'h5000_0005) begin errors++; $display("FAIL mcrf_self got %h exp %h", bus.cr_out, 32'h5000_0005); end
    idle_inputs();
    tick();
  endtask

  task automatic test_same_edge();
    bus.cmp_we = 1'b1; bus.cmp_field = 3'd2; bus.cmp_val = 4'b0010;
    issue(4'd5, 5'd8, 5'd8, 5'd8);
    tick();
    checks++; if (bus.cr_out !== 32'h5000_0A05) begin errors++; $display("FAIL same_eqv got %h exp %h", bus.cr_out, 32'h5000_0A05); end
    bus.cmp_field = 3'd3; bus.cmp_val = 4'hF;
    issue(4'd8, 5'd0, 5'd0, 5'd12);
    tick();
    checks++; if (bus.cr_out !== 32'h5000_5A05) begin errors++; $display("FAIL same_mcrf got %h exp %h", bus.cr_out, 32'h5000_5A05); end
    bus.cmp_field = 3'd1; bus.cmp_val = 4'hF;
    issue(4'd0, 5'd4, 5'd4, 5'd3);
    tick();
    checks++; if (bus.cr_out !== 32'h5000_5AF4) begin errors++; $display("FAIL same_preedge got %h exp %h", bus.cr_out, 32'h5000_5AF4); end
    checks++; if (bus.out_bit !== 1'b0) begin errors++; $display("FAIL same_preedge_bit got %b exp 0", bus.out_bit); end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    issue(4'd1, 5'd1, 5'd0, 5'd30);
    tick();
    checks++; if (bus.cr_out !== 32'h7000_5AF4) begin errors++; $display("FAIL stall_first_cr got %h exp %h", bus.cr_out, 32'h7000_5AF4); end
    issue(4'd6, 5'd1, 5'd1, 5'd1);
    bus.cmp_we = 1'b1; bus.cmp_field = 3'd4; bus.cmp_val = 4'h3;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
      tick();
      bus.cmp_we = 1'b0;
      checks++; if (bus.out_bit !== 1'b1 || bus.out_sel_t !== 5'd30 || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got v %b bit %b sel %0d exp 1 1 30", i, bus.out_valid, bus.out_bit, bus.out_sel_t);
      end
    end
    checks++; if (bus.cr_out !== 32'h7003_5AF4) begin errors++; $display("FAIL stall_cr got %h exp %h", bus.cr_out, 32'h7003_5AF4); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel_t !== 5'd1 || bus.out_bit !== 1'b0) begin
      errors++; $display("FAIL release_out got v %b bit %b sel %0d exp 1 0 1", bus.out_valid, bus.out_bit, bus.out_sel_t);
    end
    checks++; if (bus.cr_out !== 32'h7003_5AF0) begin errors++; $display("FAIL release_cr got %h exp %h", bus.cr_out, 32'h7003_5AF0); end
    tick();
  endtask

  task automatic test_illegal_reset();
    bus.out_ready = 1'b0;
    issue(4'd12, 5'd0, 5'd0, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_err !== 1'b1 || bus.out_bit !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL illegal_out got v %b err %b bit %b exp 1 1 0", bus.out_valid, bus.out_err, bus.out_bit);
    end
    checks++; if (bus.cr_out !== 32'h7003_5AF0) begin errors++; $display("FAIL illegal_cr got %h exp %h", bus.cr_out, 32'h7003_5AF0); end
    reset = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin errors++; $display("FAIL rst_drop got v %b err %b exp 0 0", bus.out_valid, bus.out_err); end
    checks++; if (bus.cr_out !== 32'h0) begin errors++; $display("FAIL rst_cr got %h exp %h", bus.cr_out, 32'h0); end
    reset = 1'b1;
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_cmp_and();
    test_back_to_back();
    test_mtcrf_mcrf();
    test_same_edge();
    test_stall();
    test_illegal_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
